// File: rtl/control_sequencer.sv
// Hard-wired control sequencer for the 32-bit bus datapath: steps fetch, decode and execute one
// control step per clock and owns the MDR read/write handshake with memory.
module control_sequencer #(
  parameter int unsigned RESET_PC_WAIT = 1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCin,
  output logic        PCout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        InPortout,
  output logic        Read,
  output logic        mem_write,
  output logic [4:0]  ALU_op,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] instr_count
);

  localparam int unsigned WaitMax = (RESET_PC_WAIT > 1) ? RESET_PC_WAIT - 1 : 0;
  localparam int unsigned WaitW   = (WaitMax > 0) ? $clog2(WaitMax + 1) : 1;
  localparam logic [4:0]  AluAdd  = 5'h00;
  localparam logic [4:0]  AluInc  = 5'h11;

  typedef enum logic [3:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } state_e;

  typedef enum logic [3:0] {
    ClsAlu, ClsAddi, ClsLd, ClsSt, ClsMulDiv, ClsMfhi, ClsMflo, ClsNop, ClsHalt, ClsIllegal
  } cls_e;

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic [31:0]      count_q, count_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             wait_done;
  logic             retire;

  logic [4:0]  op;
  logic [3:0]  ra, rb, rc;
  logic [15:0] ra_oh, rb_oh, rc_oh;
  cls_e        cls;
  logic        unused_imm;

  assign op    = ir[31:27];
  assign ra    = ir[26:23];
  assign rb    = ir[22:19];
  assign rc    = ir[18:15];
  assign ra_oh = 16'h0001 << ra;
  assign rb_oh = 16'h0001 << rb;
  assign rc_oh = 16'h0001 << rc;

  // The immediate itself is routed to the bus by the datapath when Cout is high.
  assign unused_imm = ^ir[14:0];

  assign wait_done = (wait_q == WaitW'(WaitMax));

  always_comb begin
    cls = ClsIllegal;
    case (op)
      5'h0A:        cls = ClsAddi;
      5'h0B:        cls = ClsLd;
      5'h0C:        cls = ClsSt;
      5'h0D, 5'h0E: cls = ClsMulDiv;
      5'h0F:        cls = ClsMfhi;
      5'h10:        cls = ClsMflo;
      5'h1A:        cls = ClsNop;
      5'h1B:        cls = ClsHalt;
      default:      if (op <= 5'h09) cls = ClsAlu;
    endcase
  end

  // Next state. nop/halt/illegal are resolved in T2 from the word being loaded into IR.
  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    wait_d    = wait_q;
    retire    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!wait_done) begin
          wait_d = wait_q + WaitW'(1);
        end else if (run) begin
          state_d = StT0;
        end
      end
      StT0: state_d = StT1;
      StT1: if (mem_ready) state_d = StT2;
      StT2: begin
        case (cls)
          ClsNop:     retire = 1'b1;
          ClsIllegal: begin
            retire    = 1'b1;
            illegal_d = 1'b1;
          end
          ClsHalt: begin
            state_d  = StHalt;
            halted_d = 1'b1;
          end
          default:    state_d = StT3;
        endcase
      end
      StT3: begin
        if (cls == ClsMfhi || cls == ClsMflo) retire = 1'b1;
        else state_d = StT4;
      end
      StT4: state_d = StT5;
      StT5: begin
        if (cls == ClsAlu || cls == ClsAddi) retire = 1'b1;
        else state_d = StT6;
      end
      StT6: begin
        if (cls == ClsMulDiv) retire = 1'b1;
        else if (cls == ClsSt || mem_ready) state_d = StT7;
      end
      StT7: begin
        if (cls == ClsLd || mem_ready) retire = 1'b1;
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
    if (retire) begin
      count_d = count_q + 32'd1;
      state_d = run ? StT0 : StIdle;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= StIdle;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= 32'd0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
      wait_q    <= wait_d;
    end
  end

  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;

  // Control strobes for the current step; anything not driven here stays low.
  always_comb begin
    Rin       = '0;
    Rout      = '0;
    PCin      = 1'b0;
    PCout     = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    Zhighout  = 1'b0;
    Zlowout   = 1'b0;
    HIout     = 1'b0;
    LOout     = 1'b0;
    Cout      = 1'b0;
    InPortout = 1'b0;
    Read      = 1'b0;
    mem_write = 1'b0;
    ALU_op    = AluAdd;
    unique case (state_q)
      StT0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        ALU_op = AluInc;
        Zin    = 1'b1;
      end
      StT1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = mem_ready;
      end
      StT2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      StT3: begin
        case (cls)
          ClsMfhi: begin
            HIout = 1'b1;
            Rin   = ra_oh;
          end
          ClsMflo: begin
            LOout = 1'b1;
            Rin   = ra_oh;
          end
          ClsMulDiv: begin
            Rout = ra_oh;
            Yin  = 1'b1;
          end
          default: begin
            Rout = rb_oh;
            Yin  = 1'b1;
          end
        endcase
      end
      StT4: begin
        Zin = 1'b1;
        case (cls)
          ClsAlu: begin
            ALU_op = op;
            Rout   = (op == 5'h08 || op == 5'h09) ? rb_oh : rc_oh;
          end
          ClsMulDiv: begin
            ALU_op = op;
            Rout   = rb_oh;
          end
          default: begin
            Cout   = 1'b1;
            ALU_op = AluAdd;
          end
        endcase
      end
      StT5: begin
        Zlowout = 1'b1;
        case (cls)
          ClsAlu, ClsAddi: Rin   = ra_oh;
          ClsMulDiv:       LOin  = 1'b1;
          default:         MARin = 1'b1;
        endcase
      end
      StT6: begin
        case (cls)
          ClsLd: begin
            Read  = 1'b1;
            MDRin = mem_ready;
          end
          ClsSt: begin
            Rout  = ra_oh;
            MDRin = 1'b1;
          end
          ClsMulDiv: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
          end
          default: ;
        endcase
      end
      StT7: begin
        case (cls)
          ClsLd: begin
            MDRout = 1'b1;
            Rin    = ra_oh;
          end
          ClsSt:   mem_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: every control step is compared as one packed strobe word
// against hand-written expectations.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;
  logic [15:0] Rin, Rout;
  logic        PCin, PCout, IRin, Yin, Zin, HIin, LOin, MARin, MDRin, MDRout;
  logic        Zhighout, Zlowout, HIout, LOout, Cout, InPortout, Read, mem_write;
  logic [4:0]  ALU_op;
  logic        halted, illegal;
  logic [31:0] instr_count;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  control_sequencer #(.RESET_PC_WAIT(1)) dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
    .Rin(Rin), .Rout(Rout), .PCin(PCin), .PCout(PCout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout), .Cout(Cout),
    .InPortout(InPortout), .Read(Read), .mem_write(mem_write), .ALU_op(ALU_op),
    .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  logic [54:0] ctl;
  assign ctl = {Rin, Rout, PCin, PCout, IRin, Yin, Zin, HIin, LOin, MARin, MDRin, MDRout,
                Zhighout, Zlowout, HIout, LOout, Cout, InPortout, Read, mem_write, ALU_op};

  localparam logic [54:0] BMemW   = 55'd1 << 5;
  localparam logic [54:0] BRead   = 55'd1 << 6;
  localparam logic [54:0] BCout   = 55'd1 << 8;
  localparam logic [54:0] BHiOut  = 55'd1 << 10;
  localparam logic [54:0] BZLow   = 55'd1 << 11;
  localparam logic [54:0] BZHigh  = 55'd1 << 12;
  localparam logic [54:0] BMdrOut = 55'd1 << 13;
  localparam logic [54:0] BMdrIn  = 55'd1 << 14;
  localparam logic [54:0] BMarIn  = 55'd1 << 15;
  localparam logic [54:0] BLoIn   = 55'd1 << 16;
  localparam logic [54:0] BHiIn   = 55'd1 << 17;
  localparam logic [54:0] BZin    = 55'd1 << 18;
  localparam logic [54:0] BYin    = 55'd1 << 19;
  localparam logic [54:0] BIrIn   = 55'd1 << 20;
  localparam logic [54:0] BPcOut  = 55'd1 << 21;
  localparam logic [54:0] BPcIn   = 55'd1 << 22;

  localparam logic [54:0] ExpT0  = BPcOut | BMarIn | BZin | 55'h11;
  localparam logic [54:0] ExpT1w = BZLow | BPcIn | BRead;
  localparam logic [54:0] ExpT1  = BZLow | BPcIn | BRead | BMdrIn;
  localparam logic [54:0] ExpT2  = BMdrOut | BIrIn;

  function automatic logic [54:0] rin(input int n);
    return 55'd1 << (39 + n);
  endfunction

  function automatic logic [54:0] rout(input int n);
    return 55'd1 << (23 + n);
  endfunction

  function automatic logic [54:0] alu(input logic [4:0] a);
    return {50'd0, a};
  endfunction

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] a,
                                      input logic [3:0] b, input logic [18:0] lo);
    return {op, a, b, lo};
  endfunction

  task automatic chk_ctl(input string tag, input logic [54:0] exp);
    tests++;
    assert (ctl === exp)
    else begin
      fails++;
      $error("FAIL %s: strobes got %h, want %h", tag, ctl, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Check the current step's strobes mid-cycle, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [54:0] exp);
    #1;
    chk_ctl(tag, exp);
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input string tag);
    mem_ready = 1'b1;
    cyc({tag, "_t0"}, ExpT0);
    cyc({tag, "_t1"}, ExpT1);
    cyc({tag, "_t2"}, ExpT2);
  endtask

  initial begin
    clear     = 1'b0;
    run       = 1'b0;
    ir        = 32'd0;
    mem_ready = 1'b1;
    #1;
    chk_ctl("reset_outputs", 55'd0);
    chk32("reset_halted", {31'd0, halted}, 32'd0);
    chk32("reset_illegal", {31'd0, illegal}, 32'd0);
    chk32("reset_count", instr_count, 32'd0);
    @(posedge clock);
    #1;

    // add R1,R2,R3 interrupted by clear in T4
    clear = 1'b1;
    run   = 1'b1;
    ir    = enc(5'h00, 4'd1, 4'd2, {4'd3, 15'd0});
    cyc("idle", 55'd0);
    fetch("add0");
    cyc("add0_t3", rout(2) | BYin);
    #1;
    chk_ctl("add0_t4", rout(3) | BZin | alu(5'h00));
    clear = 1'b0;
    #1;
    chk_ctl("async_clear", 55'd0);
    chk32("async_clear_count", instr_count, 32'd0);
    @(posedge clock);
    #1;
    clear = 1'b1;
    cyc("idle_after_clear", 55'd0);

    // add R1,R2,R3 complete
    fetch("add");
    cyc("add_t3", rout(2) | BYin);
    cyc("add_t4", rout(3) | BZin | alu(5'h00));
    cyc("add_t5", BZLow | rin(1));
    chk32("add_count", instr_count, 32'd1);

    // ld R4,0x10(R2) with three wait cycles in T6
    ir = enc(5'h0B, 4'd4, 4'd2, 19'h00010);
    fetch("ld");
    cyc("ld_t3", rout(2) | BYin);
    cyc("ld_t4", BCout | BZin | alu(5'h00));
    cyc("ld_t5", BZLow | BMarIn);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("ld_t6_wait", BRead);
    mem_ready = 1'b1;
    cyc("ld_t6_ready", BRead | BMdrIn);
    cyc("ld_t7", BMdrOut | rin(4));
    chk32("ld_count", instr_count, 32'd2);

    // st R5,-1(R0) with a fetch wait and two write waits
    ir = enc(5'h0C, 4'd5, 4'd0, 19'h7FFFF);
    cyc("st_t0", ExpT0);
    mem_ready = 1'b0;
    cyc("st_t1_wait", ExpT1w);
    mem_ready = 1'b1;
    cyc("st_t1", ExpT1);
    cyc("st_t2", ExpT2);
    cyc("st_t3", rout(0) | BYin);
    cyc("st_t4", BCout | BZin | alu(5'h00));
    cyc("st_t5", BZLow | BMarIn);
    cyc("st_t6", rout(5) | BMdrIn);
    mem_ready = 1'b0;
    cyc("st_t7_wait", BMemW);
    cyc("st_t7_wait", BMemW);
    mem_ready = 1'b1;
    cyc("st_t7", BMemW);
    chk32("st_count", instr_count, 32'd3);

    // mul R6,R7 then mfhi R8
    ir = enc(5'h0D, 4'd6, 4'd7, 19'd0);
    fetch("mul");
    cyc("mul_t3", rout(6) | BYin);
    cyc("mul_t4", rout(7) | BZin | alu(5'h0D));
    cyc("mul_t5", BZLow | BLoIn);
    cyc("mul_t6", BZHigh | BHiIn);
    chk32("mul_count", instr_count, 32'd4);
    ir = enc(5'h0F, 4'd8, 4'd0, 19'd0);
    fetch("mfhi");
    cyc("mfhi_t3", BHiOut | rin(8));
    chk32("mfhi_count", instr_count, 32'd5);

    // neg R9,R10 drives Rb in both operand steps
    ir = enc(5'h08, 4'd9, 4'd10, 19'd0);
    fetch("neg");
    cyc("neg_t3", rout(10) | BYin);
    cyc("neg_t4", rout(10) | BZin | alu(5'h08));
    cyc("neg_t5", BZLow | rin(9));
    chk32("neg_count", instr_count, 32'd6);

    // nop with run dropped: finishes, parks in IDLE, restarts on run
    ir = enc(5'h1A, 4'd0, 4'd0, 19'd0);
    cyc("nop_t0", ExpT0);
    cyc("nop_t1", ExpT1);
    run = 1'b0;
    cyc("nop_t2", ExpT2);
    chk32("nop_count", instr_count, 32'd7);
    cyc("idle_run0", 55'd0);
    cyc("idle_run0_hold", 55'd0);
    chk32("illegal_before", {31'd0, illegal}, 32'd0);
    run = 1'b1;
    cyc("idle_run1", 55'd0);

    // undefined opcode retires as nop and sets illegal
    ir = enc(5'h1F, 4'd3, 4'd3, 19'd0);
    fetch("ill");
    chk32("illegal_set", {31'd0, illegal}, 32'd1);
    chk32("ill_count", instr_count, 32'd8);

    // halt: sticky flag, no strobes, not counted
    ir = enc(5'h1B, 4'd0, 4'd0, 19'd0);
    fetch("halt");
    chk32("halted_set", {31'd0, halted}, 32'd1);
    chk32("halt_count", instr_count, 32'd8);
    for (int i = 0; i < 20; i++) cyc("halt_quiet", 55'd0);
    chk32("halted_sticky", {31'd0, halted}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
